coupled_weight_ctrl: RTL and testbench

Synchronous weight controller for the next-generation coupled cell. It holds `NUM_CH` coupling weights in shadow registers written over the AXI write path. On `commit` it moves them into active registers, either in one step or ramped one step at a time (annealing). The active weights drive the tap selects of the cell's asynchronous delay lines. The controller never touches the oscillator phase paths.

---
 rtl/coupled_weight_ctrl_pkg.sv | 21 ++
 rtl/coupled_weight_ctrl_lane.sv | 66 ++++++
 rtl/coupled_weight_ctrl.sv | 140 ++++++++++++++
 tb/tb_coupled_weight_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coupled_weight_ctrl_pkg.sv
// Shared constants and helpers for the coupled-cell weight controller.
//   ctrl_state_t : controller FSM encoding
//   weight_mid   : mid-scale (reset) weight for a given number of levels
//   sel_width    : channel-select width, never narrower than one bit
package coupled_weight_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_DONE = 2'd2
   } ctrl_state_t;

   function automatic int weight_mid(input int num_weights);
      return num_weights / 2;
   endfunction

   function automatic int sel_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/coupled_weight_ctrl_lane.sv
// weight_ramp_lane: one coupling channel of the weight controller.
// Holds the shadow, target and active weight of a single channel.
//   clk, rst_n : clock, async active-low reset (all weights -> mid-scale)
//   wr_en      : write shadow with wr_val (saturated to NUM_WEIGHTS-1)
//   cap        : load target from the post-write shadow value
//   load_act   : load active from the post-write shadow value (direct apply)
//   step_en    : move active one level toward target
//   shadow     : current shadow weight
//   active     : registered active weight (drives the delay-line tap select)
//   eq         : active equals target
module weight_ramp_lane
   import coupled_weight_ctrl_pkg::*;
#(
   parameter  int NUM_WEIGHTS = 13,
   localparam int WW          = $clog2(NUM_WEIGHTS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [WW-1:0] wr_val,
   input  logic          cap,
   input  logic          load_act,
   input  logic          step_en,
   output logic [WW-1:0] shadow,
   output logic [WW-1:0] active,
   output logic          eq
);

   localparam logic [WW-1:0] MID_W = WW'(weight_mid(NUM_WEIGHTS));
   localparam logic [WW-1:0] MAX_W = WW'(NUM_WEIGHTS - 1);

   logic [WW-1:0] target;
   logic [WW-1:0] shadow_nxt;

   // Commit sees the shadow as it will be after this edge, so a write in
   // the commit cycle is included.
   always_comb begin
      shadow_nxt = shadow;
      if (wr_en) begin
         shadow_nxt = (wr_val > MAX_W) ? MAX_W : wr_val;
      end
   end

   assign eq = (active == target);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= MID_W;
         target <= MID_W;
         active <= MID_W;
      end else begin
         shadow <= shadow_nxt;
         if (cap) begin
            target <= shadow_nxt;
         end
         // Single-level steps toward a target that is itself in range can
         // neither overshoot nor leave [0, NUM_WEIGHTS-1].
         if (load_act) begin
            active <= shadow_nxt;
         end else if (step_en && !eq) begin
            active <= (active < target) ? active + 1'b1 : active - 1'b1;
         end
      end
   end

endmodule

// File: rtl/coupled_weight_ctrl.sv
// coupled_weight_ctrl: coupling-weight controller for the coupled cell.
// Shadow weights are written over the AXI write path; commit applies them to
// the active weights either directly or as an annealing ramp of +-1 steps.
//   clk, axi_rstn          : AXI clock, async active-low reset
//   wready, wr_addr_match  : write strobe and address hit
//   ch_sel                 : channel for write / read
//   wdata                  : write data, low WW bits used
//   rd_shadow, rdata       : combinational read of shadow (1) or active (0)
//   commit, ramp_en        : apply request, ramp_en selects ramped apply
//   ramp_div               : cycles per ramp step minus one
//   active_w               : active weights, channel c at [c*WW +: WW]
//   busy, done             : not idle / one-cycle completion pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no apply in progress
// RAMP    | stepping active toward target, one step per divider tick
// DONE    | active equals target; done pulses for this cycle only
module coupled_weight_ctrl
   import coupled_weight_ctrl_pkg::*;
#(
   parameter  int NUM_WEIGHTS = 13,
   parameter  int NUM_CH      = 2,
   parameter  int RAMP_W      = 8,
   localparam int WW          = $clog2(NUM_WEIGHTS),
   localparam int CW          = sel_width(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 axi_rstn,
   input  logic                 wready,
   input  logic                 wr_addr_match,
   input  logic [CW-1:0]        ch_sel,
   input  logic [31:0]          wdata,
   input  logic                 rd_shadow,
   output logic [31:0]          rdata,
   input  logic                 commit,
   input  logic                 ramp_en,
   input  logic [RAMP_W-1:0]    ramp_div,
   output logic [NUM_CH*WW-1:0] active_w,
   output logic                 busy,
   output logic                 done
);

   ctrl_state_t          state;
   logic [RAMP_W-1:0]    div_cnt;
   logic [RAMP_W-1:0]    div_lat;
   logic [NUM_CH-1:0]    wr_en;
   logic [NUM_CH-1:0]    eq_vec;
   logic [NUM_CH*WW-1:0] shadow_all;
   logic [NUM_CH*WW-1:0] active_all;
   logic [WW-1:0]        rd_w;
   logic                 all_eq;
   logic                 load_act;
   logic                 step_en;
   logic                 unused_wdata;

   assign unused_wdata = ^wdata[31:WW];

   assign all_eq   = &eq_vec;
   assign load_act = commit & ~ramp_en;
   // A commit in RAMP always wins over the step for that cycle.
   assign step_en  = (state == ST_RAMP) & ~commit & ~all_eq & (div_cnt == '0);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      // Selects beyond NUM_CH-1 match no lane, so such writes drop out here.
      assign wr_en[c] = wready & wr_addr_match & (ch_sel == CW'(c));

      weight_ramp_lane #(
         .NUM_WEIGHTS (NUM_WEIGHTS)
      ) u_lane (
         .clk      (clk),
         .rst_n    (axi_rstn),
         .wr_en    (wr_en[c]),
         .wr_val   (wdata[WW-1:0]),
         .cap      (commit),
         .load_act (load_act),
         .step_en  (step_en),
         .shadow   (shadow_all[c*WW +: WW]),
         .active   (active_all[c*WW +: WW]),
         .eq       (eq_vec[c])
      );
   end

   assign active_w = active_all;

   always_comb begin
      rd_w = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel == CW'(c)) begin
            rd_w = rd_shadow ? shadow_all[c*WW +: WW] : active_all[c*WW +: WW];
         end
      end
   end

   assign rdata = {{(32-WW){1'b0}}, rd_w};

   // Divider is a down-counter loaded with the latched ramp_div; a step is
   // taken at terminal count, giving ramp_div+1 cycles per step.
   always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         div_lat <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_RAMP: begin
               if (commit && ramp_en) begin
                  div_lat <= ramp_div;
                  div_cnt <= ramp_div;
               end else if (commit || all_eq) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else if (div_cnt == '0) begin
                  div_cnt <= div_lat;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (commit && ramp_en) begin
                  state   <= ST_RAMP;
                  busy    <= 1'b1;
                  div_lat <= ramp_div;
                  div_cnt <= ramp_div;
               end else if (commit) begin
                  state <= ST_DONE;
                  busy  <= 1'b1;
                  done  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coupled_weight_ctrl.sv
// Self-checking bench for coupled_weight_ctrl. The reference model describes
// each apply as a segment: start weights, target weights, commit cycle and
// step period; the expected active weight at any cycle follows from that
// with plain arithmetic.
module tb_coupled_weight_ctrl;

   localparam int NUM_WEIGHTS = 13;
   localparam int NUM_CH      = 2;
   localparam int RAMP_W      = 8;
   localparam int WW          = 4;
   localparam int CW          = 1;
   localparam int MID         = 6;

   logic                 clk = 1'b0;
   logic                 axi_rstn = 1'b1;
   logic                 wready = 1'b0;
   logic                 wr_addr_match = 1'b0;
   logic [CW-1:0]        ch_sel = '0;
   logic [31:0]          wdata = '0;
   logic                 rd_shadow = 1'b0;
   logic [31:0]          rdata;
   logic                 commit = 1'b0;
   logic                 ramp_en = 1'b0;
   logic [RAMP_W-1:0]    ramp_div = '0;
   logic [NUM_CH*WW-1:0] active_w;
   logic                 busy;
   logic                 done;

   // single-channel instance for the out-of-range select case
   logic                 b_wready = 1'b0;
   logic                 b_wr_addr_match = 1'b0;
   logic [0:0]           b_ch_sel = '0;
   logic [31:0]          b_wdata = '0;
   logic                 b_rd_shadow = 1'b1;
   logic [31:0]          b_rdata;
   logic                 b_commit = 1'b0;
   logic                 b_ramp_en = 1'b0;
   logic [RAMP_W-1:0]    b_ramp_div = '0;
   logic [WW-1:0]        b_active_w;
   logic                 b_busy;
   logic                 b_done;

   coupled_weight_ctrl #(.NUM_WEIGHTS(NUM_WEIGHTS), .NUM_CH(NUM_CH), .RAMP_W(RAMP_W)) u_dut (
      .clk(clk), .axi_rstn(axi_rstn), .wready(wready), .wr_addr_match(wr_addr_match),
      .ch_sel(ch_sel), .wdata(wdata), .rd_shadow(rd_shadow), .rdata(rdata),
      .commit(commit), .ramp_en(ramp_en), .ramp_div(ramp_div),
      .active_w(active_w), .busy(busy), .done(done)
   );

   coupled_weight_ctrl #(.NUM_WEIGHTS(NUM_WEIGHTS), .NUM_CH(1), .RAMP_W(RAMP_W)) u_dut1 (
      .clk(clk), .axi_rstn(axi_rstn), .wready(b_wready), .wr_addr_match(b_wr_addr_match),
      .ch_sel(b_ch_sel), .wdata(b_wdata), .rd_shadow(b_rd_shadow), .rdata(b_rdata),
      .commit(b_commit), .ramp_en(b_ramp_en), .ramp_div(b_ramp_div),
      .active_w(b_active_w), .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int m_shadow[NUM_CH];
   int seg_start[NUM_CH];
   int seg_tgt[NUM_CH];
   int seg_t    = -10;
   int seg_div  = 0;
   int seg_done = -10;

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Step n of a ramp committed at cycle t is visible at t+1+n*(div+1).
   function automatic int exp_act(input int c, input int at);
      int k, n, d;
      k = at - seg_t - 1;
      n = (k < 0) ? 0 : k / (seg_div + 1);
      d = iabs(seg_tgt[c] - seg_start[c]);
      if (n > d) n = d;
      return (seg_tgt[c] >= seg_start[c]) ? seg_start[c] + n : seg_start[c] - n;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_shadow[c]  = MID;
         seg_start[c] = MID;
         seg_tgt[c]   = MID;
      end
      seg_t    = -10;
      seg_div  = 0;
      seg_done = -10;
   endtask

   task automatic model_commit(input bit ren, input int div);
      int cur[NUM_CH];
      int d_max;
      d_max = 0;
      for (int c = 0; c < NUM_CH; c++) cur[c] = exp_act(c, cyc);
      for (int c = 0; c < NUM_CH; c++) begin
         seg_tgt[c]   = m_shadow[c];
         seg_start[c] = ren ? cur[c] : m_shadow[c];
         if (iabs(seg_tgt[c] - seg_start[c]) > d_max) d_max = iabs(seg_tgt[c] - seg_start[c]);
      end
      seg_t    = cyc;
      seg_div  = ren ? div : 0;
      seg_done = ren ? cyc + 2 + d_max * (div + 1) : cyc + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      for (int c = 0; c < NUM_CH; c++)
         chk($sformatf("active_w[%0d]", c), 32'(active_w[c*WW +: WW]), 32'(exp_act(c, cyc)));
      chk("busy", 32'(busy), (cyc > seg_t && cyc <= seg_done) ? 32'd1 : 32'd0);
      chk("done", 32'(done), (cyc == seg_done) ? 32'd1 : 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic drive(input bit we, input int c, input int v, input bit cm, input bit ren, input int div);
      int w;
      wready        = we;
      wr_addr_match = we;
      ch_sel        = CW'(c);
      wdata         = 32'(v);
      commit        = cm;
      ramp_en       = ren;
      ramp_div      = RAMP_W'(div);
      if (we && c < NUM_CH) begin
         w = v % (1 << WW);
         m_shadow[c] = (w > NUM_WEIGHTS - 1) ? NUM_WEIGHTS - 1 : w;
      end
      if (cm) model_commit(ren, div);
      tick();
      wready        = 1'b0;
      wr_addr_match = 1'b0;
      commit        = 1'b0;
      ramp_en       = 1'b0;
   endtask

   task automatic read_chk(input string tag, input int c, input bit shd, input int exp);
      ch_sel    = CW'(c);
      rd_shadow = shd;
      #1;
      chk(tag, rdata, 32'(exp));
   endtask

   task automatic run_until_idle();
      int budget;
      budget = 500;
      while (cyc <= seg_done + 1 && budget > 0) begin
         tick();
         budget--;
      end
   endtask

   initial begin
      int guard;
      model_reset();
      #2 axi_rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      read_chk("rst_shadow0", 0, 1'b1, MID);
      read_chk("rst_shadow1", 1, 1'b1, MID);
      read_chk("rst_active1", 1, 1'b0, MID);
      axi_rstn = 1'b1;

      // direct apply with saturation
      drive(1, 0, 9, 0, 0, 0);
      drive(1, 1, 15, 0, 0, 0);
      read_chk("sat_shadow1", 1, 1'b1, 12);
      read_chk("shadow0", 0, 1'b1, 9);
      drive(0, 0, 0, 1, 0, 0);
      read_chk("direct_active0", 0, 1'b0, 9);
      tick();
      tick();

      // ramp ch0 down with ramp_div=3, retarget upward at active=4 with a
      // same-cycle shadow write
      drive(1, 0, 2, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 3);
      guard = 0;
      while (exp_act(0, cyc) != 4 && guard < 200) begin
         tick();
         guard++;
      end
      drive(1, 0, 8, 1, 1, 3);
      run_until_idle();

      // ramp then abort, with a same-cycle write
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 2);
      repeat (7) tick();
      drive(1, 1, 5, 1, 0, 0);
      run_until_idle();

      // ramp to an already-equal target
      drive(0, 0, 0, 1, 1, 5);
      run_until_idle();

      // randomized applies, writes during ramps, retargets and aborts
      for (int it = 0; it < 12; it++) begin
         drive(1, 0, int'($urandom_range(0, 15)), 0, 0, 0);
         drive(1, 1, int'($urandom_range(0, 15)), 1, int'($urandom_range(0, 3)) != 0, int'($urandom_range(0, 3)));
         repeat (int'($urandom_range(0, 20))) begin
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 0, 0, 0);
         end
         if ($urandom_range(0, 2) == 0)
            drive(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)));
         run_until_idle();
      end

      // asynchronous reset in the middle of a ramp
      drive(1, 0, 12, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 12, 1, 1, 2);
      repeat (5) tick();
      #2 axi_rstn = 1'b0;
      #1;
      chk("rst_async_act0", 32'(active_w[WW-1:0]), MID);
      chk("rst_async_act1", 32'(active_w[2*WW-1:WW]), MID);
      chk("rst_async_busy", 32'(busy), 0);
      chk("rst_async_done", 32'(done), 0);
      model_reset();
      repeat (2) tick();
      axi_rstn = 1'b1;
      repeat (3) tick();
      read_chk("post_rst_shadow0", 0, 1'b1, MID);

      // single-channel instance: select 1 is out of range
      b_wready = 1'b1; b_wr_addr_match = 1'b1; b_ch_sel = 1'b1; b_wdata = 32'd3;
      @(posedge clk); #1;
      b_wready = 1'b0; b_wr_addr_match = 1'b0;
      #1 chk("oor_rdata", b_rdata, 0);
      b_ch_sel = 1'b0;
      #1 chk("oor_ignored", b_rdata, MID);
      b_wready = 1'b1; b_wr_addr_match = 1'b1; b_wdata = 32'd3;
      @(posedge clk); #1;
      b_wready = 1'b0; b_wr_addr_match = 1'b0;
      #1 chk("ch0_write", b_rdata, 3);
      chk("ch1_active", 32'(b_active_w), MID);
      chk("ch1_busy", 32'(b_busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
